// File: rtl/capture_seq.sv
// Capture sequencer: circular acquisition over a 2^AW sample RAM, then a frozen readout pointer.
// Optional auto-trigger timeout is built when TRIG_TIMEOUT_EN is defined.
module capture_seq #(
  parameter int AW = 12,
  parameter int TW = 16
) (
  input  logic          Clk,
  input  logic          nRst,
  input  logic          Start,
  input  logic          Abort,
  input  logic          Sample_en,
  input  logic          Trig,
  input  logic [AW-1:0] Pre_depth,
  input  logic [AW-1:0] Post_depth,
  input  logic [TW-1:0] Timeout,
  input  logic          Rd_next,
  output logic [AW-1:0] Waddr,
  output logic          We,
  output logic [AW-1:0] Raddr,
  output logic [AW-1:0] Trig_addr,
  output logic          Busy,
  output logic          Ready,
  output logic          Auto_trig
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [AW:0]   ONE_C = (AW+1)'(1);

  // Post depth is clipped so pre + post never exceeds the buffer.
  function automatic logic [AW-1:0] post_eff_f(input logic [AW-1:0] pre,
                                               input logic [AW-1:0] post);
    logic [AW:0] room;
    room = {1'b1, {AW{1'b0}}} - {1'b0, pre};
    if ({1'b0, post} < room) return post;
    return room[AW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, raddr_q, taddr_q, cnt_q, pre_q, post_q;
  logic [AW:0]   cnt_inc;
  logic          active, we_c, start_ok, fire, auto_fire;

`ifdef TRIG_TIMEOUT_EN
  logic [TW-1:0] tmo_q, tcnt_q;
  logic          auto_q;

  assign auto_fire = (state_q == S_ARMED) && Sample_en && !Trig && (tmo_q != '0) &&
                     ((tcnt_q + TW'(1)) == tmo_q);

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      tmo_q  <= '0;
      tcnt_q <= '0;
      auto_q <= 1'b0;
    end else begin
      if (start_ok) begin
        tmo_q  <= Timeout;
        auto_q <= 1'b0;
      end else if (fire) begin
        auto_q <= auto_fire;
      end
      if (state_q != S_ARMED) tcnt_q <= '0;
      else if (Sample_en)     tcnt_q <= tcnt_q + TW'(1);
    end
  end

  assign Auto_trig = auto_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^Timeout;
  assign auto_fire      = 1'b0;
  assign Auto_trig      = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    fire     = 1'b0;
    active   = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    we_c     = Sample_en && active;
    cnt_inc  = {1'b0, cnt_q} + ONE_C;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d  = S_PRE;
          start_ok = 1'b1;
        end
      end
      S_PRE: begin
        if ((pre_q == '0) || (we_c && (cnt_inc == {1'b0, pre_q}))) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (Trig || auto_fire) begin
          fire    = 1'b1;
          state_d = S_POST;
        end
      end
      S_POST: begin
        if ((post_q == '0) || (we_c && (cnt_inc == {1'b0, post_q}))) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides Start and any trigger in the same cycle.
    if (Abort) begin
      state_d  = S_IDLE;
      start_ok = 1'b0;
      fire     = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      wptr_q  <= '0;
      raddr_q <= '0;
      taddr_q <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      post_q  <= '0;
    end else if (start_ok) begin
      wptr_q <= '0;
      cnt_q  <= '0;
      pre_q  <= Pre_depth;
      post_q <= post_eff_f(Pre_depth, Post_depth);
    end else begin
      if (we_c) wptr_q <= wptr_q + ONE_A;
      if (state_d != state_q) cnt_q <= '0;
      else if (we_c)          cnt_q <= cnt_q + ONE_A;
      // A write in the trigger cycle is still pre-trigger; the next slot is the first post sample.
      if (fire) taddr_q <= we_c ? (wptr_q + ONE_A) : wptr_q;
      if ((state_q == S_POST) && (state_d == S_DONE)) raddr_q <= taddr_q - pre_q;
      else if ((state_q == S_DONE) && (state_d == S_DONE) && Rd_next) raddr_q <= raddr_q + ONE_A;
    end
  end

  assign We        = we_c;
  assign Waddr     = wptr_q;
  assign Raddr     = raddr_q;
  assign Trig_addr = taddr_q;
  assign Busy      = active;
  assign Ready     = (state_q == S_DONE);

endmodule

// File: tb/tb_capture_seq.sv
// Directed bench for capture_seq: per-cycle vector table plus hand-written long-record sequences.
module tb_capture_seq;
  localparam int AW = 12;
  localparam int TW = 16;

  logic          Clk = 1'b0;
  logic          nRst, Start, Abort, Sample_en, Trig, Rd_next;
  logic [AW-1:0] Pre_depth, Post_depth;
  logic [TW-1:0] Timeout;
  logic [AW-1:0] Waddr, Raddr, Trig_addr;
  logic          We, Busy, Ready, Auto_trig;

  int checks = 0;
  int errors = 0;
  int bad;

  typedef struct {
    int st, ab, se, tr, rd;
    int we, busy, ready, waddr, raddr, taddr;
  } vec_t;
  vec_t tbl[18];

  capture_seq #(.AW(AW), .TW(TW)) dut (
    .Clk(Clk), .nRst(nRst), .Start(Start), .Abort(Abort), .Sample_en(Sample_en),
    .Trig(Trig), .Pre_depth(Pre_depth), .Post_depth(Post_depth), .Timeout(Timeout),
    .Rd_next(Rd_next), .Waddr(Waddr), .We(We), .Raddr(Raddr), .Trig_addr(Trig_addr),
    .Busy(Busy), .Ready(Ready), .Auto_trig(Auto_trig)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic se, input logic tr, input logic rd);
    @(negedge Clk);
    Start = st; Abort = ab; Sample_en = se; Trig = tr; Rd_next = rd;
    #1;
  endtask

  initial begin
    nRst = 1'b0; Start = 1'b0; Abort = 1'b0; Sample_en = 1'b0; Trig = 1'b0; Rd_next = 1'b0;
    Pre_depth = '0; Post_depth = '0; Timeout = '0;

    //            st ab se tr rd  we bz rdy wa ra ta
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 0,  1, 1, 0,  0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 0,  1, 1, 0,  1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0,  0, 1, 0,  2, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0,  1, 1, 0,  2, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0,  0, 1, 0,  3, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 1,  1, 1, 0,  3, 0, 3};
    tbl[7]  = '{0, 0, 1, 0, 0,  1, 1, 0,  4, 0, 3};
    tbl[8]  = '{0, 0, 0, 0, 0,  0, 1, 0,  5, 0, 3};
    tbl[9]  = '{0, 0, 1, 0, 0,  1, 1, 0,  5, 0, 3};
    tbl[10] = '{0, 0, 1, 0, 0,  0, 0, 1,  6, 1, 3};
    tbl[11] = '{0, 0, 0, 0, 1,  0, 0, 1,  6, 1, 3};
    tbl[12] = '{0, 0, 0, 0, 1,  0, 0, 1,  6, 2, 3};
    tbl[13] = '{0, 0, 0, 0, 0,  0, 0, 1,  6, 3, 3};
    tbl[14] = '{1, 0, 0, 0, 0,  0, 0, 1,  6, 3, 3};
    tbl[15] = '{0, 0, 1, 0, 0,  1, 1, 0,  0, 3, 3};
    tbl[16] = '{0, 1, 0, 0, 0,  0, 1, 0,  1, 3, 3};
    tbl[17] = '{0, 0, 1, 0, 0,  0, 0, 0,  1, 3, 3};

    #12;
    chk("rst_we", int'(We), 0);
    chk("rst_waddr", int'(Waddr), 0);
    chk("rst_raddr", int'(Raddr), 0);
    chk("rst_taddr", int'(Trig_addr), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_ready", int'(Ready), 0);
    chk("rst_auto", int'(Auto_trig), 0);
    @(negedge Clk);
    nRst = 1'b1;

    // Short capture: Pre=2, Post=3, with trigger-in-PRE, no-write trigger, readout and abort.
    Pre_depth = 12'd2; Post_depth = 12'd3;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].st != 0, tbl[i].ab != 0, tbl[i].se != 0, tbl[i].tr != 0, tbl[i].rd != 0);
      chk($sformatf("tbl%0d_we", i), int'(We), tbl[i].we);
      chk($sformatf("tbl%0d_busy", i), int'(Busy), tbl[i].busy);
      chk($sformatf("tbl%0d_ready", i), int'(Ready), tbl[i].ready);
      chk($sformatf("tbl%0d_waddr", i), int'(Waddr), tbl[i].waddr);
      chk($sformatf("tbl%0d_raddr", i), int'(Raddr), tbl[i].raddr);
      chk($sformatf("tbl%0d_taddr", i), int'(Trig_addr), tbl[i].taddr);
    end

    // Pre=100, Post=200, continuous strobes; early Trig must be ignored.
    Pre_depth = 12'd100; Post_depth = 12'd200;
    step(1, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 350; i++) begin
      step(0, 0, 1, (i == 50) || (i == 149), 0);
      if (!(We && int'(Waddr) == i && Busy && !Ready)) bad++;
      if (i == 100) chk("A_pre_trig_ignored", int'(Trig_addr), 3);
    end
    chk("A_write_stream", bad, 0);
    step(0, 0, 1, 0, 0);
    chk("A_ready", int'(Ready), 1);
    chk("A_we_done", int'(We), 0);
    chk("A_busy_done", int'(Busy), 0);
    chk("A_taddr", int'(Trig_addr), 150);
    chk("A_raddr0", int'(Raddr), 50);
    bad = 0;
    for (int r = 0; r < 300; r++) begin
      step(0, 0, 0, 0, 1);
      if (int'(Raddr) != 50 + r) bad++;
    end
    chk("A_read_walk", bad, 0);
    step(0, 0, 0, 0, 0);
    chk("A_raddr_end", int'(Raddr), 350);

    // Pre=4000, Post=4000 -> 96 post samples; trigger after the write pointer wraps.
    Pre_depth = 12'd4000; Post_depth = 12'd4000;
    step(1, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 4197; i++) begin
      step(0, 0, 1, i == 4100, 0);
      if (!(We && int'(Waddr) == (i % 4096) && Busy && !Ready)) bad++;
    end
    chk("B_write_stream", bad, 0);
    step(0, 0, 1, 0, 0);
    chk("B_ready", int'(Ready), 1);
    chk("B_taddr", int'(Trig_addr), 5);
    chk("B_raddr0", int'(Raddr), 101);
    bad = 0;
    for (int r = 0; r < 4000; r++) begin
      step(0, 0, 0, 0, 1);
      if (int'(Raddr) != (101 + r) % 4096) bad++;
      if (r == 3994) chk("B_raddr_4095", int'(Raddr), 4095);
      if (r == 3995) chk("B_raddr_wrap0", int'(Raddr), 0);
    end
    chk("B_read_walk", bad, 0);

    // Pre=0, Post=0, no strobes: trigger on the first ARMED cycle.
    Pre_depth = 12'd0; Post_depth = 12'd0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("C_pre_busy", int'(Busy), 1);
    step(0, 0, 0, 1, 0);
    chk("C_armed_busy", int'(Busy), 1);
    step(0, 0, 0, 0, 0);
    chk("C_post_ready", int'(Ready), 0);
    chk("C_post_taddr", int'(Trig_addr), 0);
    step(0, 0, 0, 0, 0);
    chk("C_ready", int'(Ready), 1);
    chk("C_raddr", int'(Raddr), 0);
    chk("C_waddr", int'(Waddr), 0);

    // Abort together with Start during POST, then restart.
    Pre_depth = 12'd2; Post_depth = 12'd10;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      if (We || Busy || Ready || int'(Waddr) != 5) bad++;
    end
    chk("D_abort_idle", bad, 0);
    chk("D_taddr_hold", int'(Trig_addr), 2);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("D_restart_we", int'(We), 1);
    chk("D_restart_waddr", int'(Waddr), 0);
    step(0, 1, 0, 0, 0);

    Pre_depth = 12'd1; Post_depth = 12'd2; Timeout = 16'd10;
`ifdef TRIG_TIMEOUT_EN
    step(1, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 1, 0, 0);
      if (!(We && int'(Waddr) == i && !Ready)) bad++;
    end
    chk("E_auto_stream", bad, 0);
    step(0, 0, 0, 0, 0);
    chk("E_auto_ready", int'(Ready), 1);
    chk("E_auto_flag", int'(Auto_trig), 1);
    chk("E_auto_taddr", int'(Trig_addr), 11);
    chk("E_auto_raddr", int'(Raddr), 10);
    step(1, 0, 0, 0, 0);
    chk("E_auto_held", int'(Auto_trig), 1);
    step(0, 0, 0, 0, 0);
    chk("E_auto_cleared", int'(Auto_trig), 0);
    for (int i = 0; i < 13; i++) step(0, 0, 1, i == 10, 0);
    step(0, 0, 0, 0, 0);
    chk("E_real_ready", int'(Ready), 1);
    chk("E_real_flag", int'(Auto_trig), 0);
    chk("E_real_taddr", int'(Trig_addr), 11);
`else
    step(1, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 0, 0);
      if (!(We && int'(Waddr) == i && Busy && !Ready)) bad++;
    end
    chk("E_armed_waits", bad, 0);
    chk("E_taddr_hold", int'(Trig_addr), 2);
    chk("E_auto_tied0", int'(Auto_trig), 0);
    step(0, 1, 0, 0, 0);
`endif

    // Asynchronous reset mid-ARMED with strobes active.
    Pre_depth = 12'd3; Post_depth = 12'd5;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    chk("F_pre_reset_waddr", int'(Waddr), 5);
    nRst = 1'b0;
    #1;
    chk("F_rst_we", int'(We), 0);
    chk("F_rst_waddr", int'(Waddr), 0);
    chk("F_rst_raddr", int'(Raddr), 0);
    chk("F_rst_taddr", int'(Trig_addr), 0);
    chk("F_rst_busy", int'(Busy), 0);
    chk("F_rst_ready", int'(Ready), 0);
    chk("F_rst_auto", int'(Auto_trig), 0);
    @(negedge Clk);
    nRst = 1'b1;
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("F_idle_we", int'(We), 0);
    chk("F_idle_busy", int'(Busy), 0);
    chk("F_idle_waddr", int'(Waddr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_seq.md
# capture_seq

Capture sequencer for the 4096 x 18 sample RAM. It runs the RAM as a circular acquisition buffer: it generates the write address and write enable from the ADC sample strobe and holds a programmed pre-trigger depth. After a trigger it writes a programmed post-trigger depth, then freezes and presents a read pointer that walks the frozen record from its oldest sample for MCU readout. It sits between the trigger logic, the MCU register interface and the sample RAM address/enable inputs.

## Interface
- AW, 12, address width; buffer depth is 2^AW = 4096.
- TW, 16, width of the auto-trigger timeout counter.
- Clk  in  1  system clock, rising edge.
- nRst  in  1  asynchronous reset, active-low.
- Start  in  1  one-cycle pulse; begins a capture.
- Abort  in  1  one-cycle pulse; returns to IDLE from any state.
- Sample_en  in  1  one-cycle strobe; a new sample is valid on RAM Din this cycle.
- Trig  in  1  trigger event, sampled every Clk.
- Pre_depth  in  AW  pre-trigger sample count, 0..4095; latched on Start.
- Post_depth  in  AW  post-trigger sample count, 0..4095; latched on Start.
- Timeout  in  TW  auto-trigger limit in Sample_en strobes; latched on Start.
- Rd_next  in  1  one-cycle pulse; advances the read pointer.
- Waddr  out  AW  RAM write address.
- We  out  1  RAM write enable.
- Raddr  out  AW  RAM read address.
- Trig_addr  out  AW  address of the first post-trigger sample.
- Busy  out  1  capture in progress (PRE, ARMED or POST).
- Ready  out  1  record complete and frozen (DONE).
- Auto_trig  out  1  the trigger in the last capture was forced by timeout.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE. Encoding is free.
- Start is honoured only in IDLE or DONE. On Start:
  - Wptr <= 0, counters cleared, Ready <= 0, Auto_trig <= 0.
  - Depths and Timeout are latched.
  - Next state is PRE.
- Effective post depth is Post_eff = min(Post_depth, 4096 - Pre_depth).
- We = Sample_en AND state is PRE, ARMED or POST. Waddr = Wptr. Wptr increments modulo 4096 on each write.
- PRE:
  - Count writes. Go to ARMED on the write that makes the count equal Pre_depth.
  - If Pre_depth = 0, go to ARMED on the first cycle after Start.
  - Trig is ignored in PRE.
- ARMED:
  - Writes continue, overwriting the oldest data.
  - Trig = 1: Trig_addr <= Wptr, or Wptr+1 if a write occurs in the same cycle. Then go to POST.
- POST:
  - Count writes. Go to DONE on the write that makes the count equal Post_eff.
  - If Post_eff = 0, go to DONE on the next cycle.
- DONE:
  - We = 0. Ready = 1.
  - On entry, Raddr <= Trig_addr - Pre_depth (mod 4096).
  - Each Rd_next increments Raddr modulo 4096. Rd_next outside DONE is ignored.
- Abort:
  - Next state is IDLE. Ready and Busy drop; Wptr, Raddr and Trig_addr hold.
  - Abort beats Start when both arrive in the same cycle.
- Busy = state is PRE, ARMED or POST.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- We is combinational from Sample_en and the registered state.
- Waddr and Raddr come directly from registers.
- The sample RAM reads on the falling edge of its read clock. The MCU samples Dout at least one full Clk after Rd_next or after Ready rises.
- Latency from Start to the first possible write: 1 Clk (Sample_en in the cycle after Start).
- Latency from the last post-trigger write to Ready = 1: 1 Clk.
- Trig in the same cycle as the final PRE write: ignored, because the state is still PRE.
- Trig and Abort in the same cycle: Abort wins and Trig_addr is not updated.
- Wrap-around: Wptr and Raddr roll from 4095 to 0 with no flag. The record is always contiguous modulo 4096.
- Reset mid-capture: asynchronous return to reset values. RAM contents are undefined from the controller's view.

## Configuration
- TRIG_TIMEOUT_EN defined:
  - In ARMED, count Sample_en strobes from ARMED entry.
  - When the count reaches Timeout with no Trig, force a trigger exactly as for Trig, and set Auto_trig <= 1 (held until the next Start).
  - Timeout = 0 disables the auto-trigger.
  - A real Trig in the same cycle counts as real; Auto_trig stays 0.
- TRIG_TIMEOUT_EN undefined:
  - The timeout counter is absent. Timeout is ignored and Auto_trig is tied 0.
  - ARMED waits indefinitely.

## Test plan
- Pre=100, Post=200, Sample_en every cycle, Trig 50 cycles after ARMED entry:
  - Exactly 100 writes before ARMED, and Trig ignored before then.
  - Trig_addr = 150.
  - Ready 1 Clk after write #350.
  - Raddr = 50; 300 Rd_next pulses walk 50..349.
- Pre=4000, Post=4000: Post_eff = 96.
  - Let ARMED run until Wptr wraps past 4095, then Trig.
  - Raddr = Trig_addr - 4000 mod 4096, and reads wrap 4095 to 0.
- Pre=0, Post=0, Trig on the first ARMED cycle: no writes, Ready 1 Clk after POST entry, Raddr = Trig_addr.
- Abort during POST together with Start: state IDLE, Busy=0, Ready=0, no further We.
  - A second Start then restarts from Wptr=0.
- TRIG_TIMEOUT_EN, Timeout=10, no Trig: forced trigger on the 10th ARMED strobe, Auto_trig=1 until the next Start.
  - Repeat with Trig on the 10th strobe: Auto_trig=0.
- nRst asserted mid-ARMED with Sample_en active: all outputs 0 asynchronously; state IDLE after release.
